la_capture_ctrl: RTL
====================

// Module: la_capture_ctrl
// PURPOSE
//  Sequencer for the logic-analyzer sampling core and its sample FIFO. Decodes host command bytes,
//  writes the core's 8-bit config register, counts captured samples and stops the core at the
//  requested length. Then drains the FIFO to a byte-stream TX port (UART bridge) as a framed dump.
//  Sits between the host command/UART path and the analyzer core + sample FIFO.
// PARAMETERS
//  CNT_W        16    width of sample length/counters
//  MAX_SAMPLES  4096  capture length clamp (FIFO depth); LEN=0 or LEN>MAX_SAMPLES -> MAX_SAMPLES
//  STOP_WAIT    4     cycles between stop-config write and start of drain (core pipeline settle)
//  HDR_BYTE     8'hA5 first byte of every dump frame
// PORTS
//  clk            in   1  system clock
//  rst            in   1  synchronous reset, active high
//  cmd_valid      in   1  host command byte valid
//  cmd_data       in   8  host command byte
//  cmd_ready      out  1  command byte accepted when cmd_valid&cmd_ready
//  la_config_valid out 1  one-cycle write strobe to analyzer config register
//  la_config_in   out  8  config byte (bit0 free-run, bit3 edge select, [6:4] rate; 0x00 = stop)
//  la_fifo_wen    in   1  analyzer FIFO write strobe (monitored, one per sample)
//  la_fifo_alfull in   1  sample FIFO almost full
//  fifo_rd_en     out  1  sample FIFO read strobe; data valid on fifo_rd_data next cycle
//  fifo_rd_data   in   8  sample FIFO read data
//  fifo_empty     in   1  sample FIFO empty
//  tx_valid       out  1  dump byte valid; held with tx_data stable until tx_ready
//  tx_data        out  8  dump byte
//  tx_ready       in   1  downstream accepts byte when tx_valid&tx_ready
//  busy           out  1  high in any state other than IDLE
//  done           out  1  one-cycle pulse when dump frame fully sent
//  truncated      out  1  sticky: last capture ended on alfull/abort; cleared at next START
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, cfg_reg=0, len_reg=MAX_SAMPLES, counters 0. Reset mid-op
//   aborts immediately; no stop config is issued.
//  Commands: 0x01 CFG +1 arg byte -> cfg_reg; 0x02 LEN +2 arg bytes (hi,lo) -> len_reg (clamped);
//   0x03 START; 0x04 ABORT; other opcodes consumed and dropped.
//  cmd_ready: 1 in IDLE, ARG, CAPTURE; 0 otherwise. In CAPTURE only ABORT acts, rest dropped.
//  FSM: IDLE -> ARG (CFG/LEN, collect args) -> IDLE.
//   IDLE --START, cfg_reg!=0--> ARM; START with cfg_reg==0 ignored.
//   ARM (1 cycle): la_config_valid=1, la_config_in=cfg_reg, cap_cnt=0, truncated=0 -> CAPTURE.
//   CAPTURE: each la_fifo_wen increments cap_cnt. Exit when the wen cycle makes cap_cnt==len_reg,
//    or la_fifo_alfull (truncated=1), or ABORT accepted (truncated=1) -> STOP.
//    Same-cycle wen+exit: that sample is counted.
//   STOP: cycle 1 la_config_valid=1, la_config_in=0x00; wait STOP_WAIT cycles; wen ignored -> HDR.
//   HDR: send HDR_BYTE, cap_cnt[15:8], cap_cnt[7:0] -> DRAIN (cap_cnt==0 -> FLUSH).
//   DRAIN: while no byte pending and !fifo_empty, pulse fifo_rd_en; next cycle load tx_data,
//    tx_valid=1; hold until tx_ready; repeat until cap_cnt bytes sent -> FLUSH.
//    fifo_empty with bytes owed: wait, no timeout.
//   FLUSH: pulse fifo_rd_en while !fifo_empty, data discarded (late samples); empty -> FIN.
//   FIN: done=1 one cycle -> IDLE.
//  At most one fifo_rd_en outstanding; never assert fifo_rd_en when fifo_empty.
//  Counters saturate at MAX_SAMPLES; no wrap.
// TESTING
//  T1 CFG 0x31, LEN 0x0010, START; core emits 16 wen -> one config 0x31 then 0x00 strobe;
//     TX: A5 00 10 + 16 FIFO bytes in order; done pulse.
//  T2 START with cfg_reg=0 -> no la_config_valid, busy stays 0.
//  T3 LEN 100, alfull at sample 40 -> stop issued, truncated=1, header A5 00 28, 40 bytes.
//  T4 ABORT after 5 samples; 2 extra samples arrive in STOP_WAIT -> header count 5,
//     5 bytes sent, 2 flushed, FIFO empty at done.
//  T5 tx_ready low 20 cycles mid-drain -> tx_valid/tx_data stable; no extra fifo_rd_en.
//  T6 rst asserted in DRAIN -> next cycle all outputs 0, IDLE; fresh START works normally.

Source files
------------

// File: rtl/la_capture_ctrl_if.sv
// rtl/la_capture_ctrl_if.sv - Host command, analyzer core, sample FIFO and dump TX signal bundle
interface la_capture_ctrl_if;
    logic       cmd_valid;
    logic [7:0] cmd_data;
    logic       cmd_ready;
    logic       la_config_valid;
    logic [7:0] la_config_in;
    logic       la_fifo_wen;
    logic       la_fifo_alfull;
    logic       fifo_rd_en;
    logic [7:0] fifo_rd_data;
    logic       fifo_empty;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       tx_ready;
    logic       busy;
    logic       done;
    logic       truncated;

    modport master (
        input  cmd_valid, cmd_data, la_fifo_wen, la_fifo_alfull, fifo_rd_data, fifo_empty, tx_ready,
        output cmd_ready, la_config_valid, la_config_in, fifo_rd_en, tx_valid, tx_data,
               busy, done, truncated
    );

    modport slave (
        output cmd_valid, cmd_data, la_fifo_wen, la_fifo_alfull, fifo_rd_data, fifo_empty, tx_ready,
        input  cmd_ready, la_config_valid, la_config_in, fifo_rd_en, tx_valid, tx_data,
               busy, done, truncated
    );
endinterface

// File: rtl/la_capture_ctrl.sv
// rtl/la_capture_ctrl.sv - Logic-analyzer capture sequencer: command decode, capture count, framed FIFO dump
module la_capture_ctrl #(
    parameter int         CNT_W       = 16,
    parameter int         MAX_SAMPLES = 4096,
    parameter int         STOP_WAIT   = 4,
    parameter logic [7:0] HDR_BYTE    = 8'hA5
) (
    input  logic               clk,
    input  logic               rst,
    la_capture_ctrl_if.master  bus
);
    typedef enum logic [3:0] {
        S_IDLE, S_ARG, S_ARM, S_CAPTURE, S_STOP, S_HDR, S_DRAIN, S_FLUSH, S_FIN
    } state_t;

    localparam logic [CNT_W-1:0] MAX_C     = CNT_W'(MAX_SAMPLES);
    localparam logic [7:0]       WAIT_LAST = 8'(STOP_WAIT - 1);

    state_t           state_q, state_d;
    logic             arg_len_q, arg_len_d;
    logic             arg_idx_q, arg_idx_d;
    logic [7:0]       len_hi_q, len_hi_d;
    logic [7:0]       cfg_q, cfg_d;
    logic [CNT_W-1:0] len_q, len_d;
    logic [CNT_W-1:0] cap_cnt_q, cap_cnt_d;
    logic [CNT_W-1:0] sent_q, sent_d;
    logic [7:0]       wait_q, wait_d;
    logic [1:0]       hdr_idx_q, hdr_idx_d;
    logic             rd_pend_q, rd_pend_d;
    logic             tx_valid_q, tx_valid_d;
    logic [7:0]       tx_data_q, tx_data_d;
    logic             trunc_q, trunc_d;

    logic             cmd_ready, rd_en, tx_valid;
    logic [7:0]       tx_data;
    logic [15:0]      cap16;
    logic [CNT_W-1:0] cap_inc;
    logic             cmd_fire, tx_fire;

    // LEN of zero or beyond FIFO depth both mean "fill the FIFO"
    function automatic logic [CNT_W-1:0] clamp_len(input logic [15:0] v);
        if (v == 16'd0 || v > 16'(MAX_SAMPLES)) return MAX_C;
        return CNT_W'(v);
    endfunction

    assign cap16    = 16'(cap_cnt_q);
    assign cap_inc  = (cap_cnt_q == MAX_C) ? cap_cnt_q : cap_cnt_q + CNT_W'(1);
    assign cmd_fire = bus.cmd_valid && cmd_ready;
    assign tx_fire  = tx_valid && bus.tx_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            arg_len_q  <= 1'b0;
            arg_idx_q  <= 1'b0;
            len_hi_q   <= 8'h00;
            cfg_q      <= 8'h00;
            len_q      <= MAX_C;
            cap_cnt_q  <= '0;
            sent_q     <= '0;
            wait_q     <= 8'h00;
            hdr_idx_q  <= 2'd0;
            rd_pend_q  <= 1'b0;
            tx_valid_q <= 1'b0;
            tx_data_q  <= 8'h00;
            trunc_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            arg_len_q  <= arg_len_d;
            arg_idx_q  <= arg_idx_d;
            len_hi_q   <= len_hi_d;
            cfg_q      <= cfg_d;
            len_q      <= len_d;
            cap_cnt_q  <= cap_cnt_d;
            sent_q     <= sent_d;
            wait_q     <= wait_d;
            hdr_idx_q  <= hdr_idx_d;
            rd_pend_q  <= rd_pend_d;
            tx_valid_q <= tx_valid_d;
            tx_data_q  <= tx_data_d;
            trunc_q    <= trunc_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        arg_len_d  = arg_len_q;
        arg_idx_d  = arg_idx_q;
        len_hi_d   = len_hi_q;
        cfg_d      = cfg_q;
        len_d      = len_q;
        cap_cnt_d  = cap_cnt_q;
        sent_d     = sent_q;
        wait_d     = wait_q;
        hdr_idx_d  = hdr_idx_q;
        rd_pend_d  = rd_pend_q;
        tx_valid_d = tx_valid_q;
        tx_data_d  = tx_data_q;
        trunc_d    = trunc_q;
        case (state_q)
            S_IDLE: if (cmd_fire) begin
                case (bus.cmd_data)
                    8'h01: begin arg_len_d = 1'b0; arg_idx_d = 1'b0; state_d = S_ARG; end
                    8'h02: begin arg_len_d = 1'b1; arg_idx_d = 1'b0; state_d = S_ARG; end
                    8'h03: if (cfg_q != 8'h00) state_d = S_ARM;
                    default: ;
                endcase
            end
            S_ARG: if (cmd_fire) begin
                if (!arg_len_q) begin
                    cfg_d   = bus.cmd_data;
                    state_d = S_IDLE;
                end else if (!arg_idx_q) begin
                    len_hi_d  = bus.cmd_data;
                    arg_idx_d = 1'b1;
                end else begin
                    len_d   = clamp_len({len_hi_q, bus.cmd_data});
                    state_d = S_IDLE;
                end
            end
            S_ARM: begin
                cap_cnt_d  = '0;
                sent_d     = '0;
                wait_d     = 8'h00;
                hdr_idx_d  = 2'd0;
                rd_pend_d  = 1'b0;
                tx_valid_d = 1'b0;
                trunc_d    = 1'b0;
                state_d    = S_CAPTURE;
            end
            S_CAPTURE: begin
                if (bus.la_fifo_wen) begin
                    cap_cnt_d = cap_inc;
                    if (cap_inc >= len_q) state_d = S_STOP;
                end
                if (bus.la_fifo_alfull || (cmd_fire && bus.cmd_data == 8'h04)) begin
                    trunc_d = 1'b1;
                    state_d = S_STOP;
                end
            end
            S_STOP: begin
                wait_d = wait_q + 8'd1;
                if (wait_q == WAIT_LAST) state_d = S_HDR;
            end
            S_HDR: if (tx_fire) begin
                hdr_idx_d = hdr_idx_q + 2'd1;
                if (hdr_idx_q == 2'd2) state_d = (cap_cnt_q == '0) ? S_FLUSH : S_DRAIN;
            end
            S_DRAIN: begin
                rd_pend_d = rd_en;
                if (rd_pend_q) begin
                    tx_valid_d = 1'b1;
                    tx_data_d  = bus.fifo_rd_data;
                end
                if (tx_fire) begin
                    tx_valid_d = 1'b0;
                    sent_d     = sent_q + CNT_W'(1);
                    if (sent_q + CNT_W'(1) >= cap_cnt_q) state_d = S_FLUSH;
                end
            end
            S_FLUSH: begin
                rd_pend_d = rd_en;
                if (bus.fifo_empty && !rd_pend_q) state_d = S_FIN;
            end
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        cmd_ready           = 1'b0;
        bus.la_config_valid = 1'b0;
        bus.la_config_in    = 8'h00;
        rd_en               = 1'b0;
        tx_valid            = 1'b0;
        tx_data             = 8'h00;
        case (state_q)
            S_IDLE, S_ARG, S_CAPTURE: cmd_ready = !rst;
            S_ARM: begin
                bus.la_config_valid = 1'b1;
                bus.la_config_in    = cfg_q;
            end
            S_STOP: bus.la_config_valid = (wait_q == 8'h00);
            S_HDR: begin
                tx_valid = 1'b1;
                case (hdr_idx_q)
                    2'd0:    tx_data = HDR_BYTE;
                    2'd1:    tx_data = cap16[15:8];
                    default: tx_data = cap16[7:0];
                endcase
            end
            // One read in flight at a time, and only once the previous byte has left
            S_DRAIN: begin
                rd_en    = !tx_valid_q && !rd_pend_q && !bus.fifo_empty && (sent_q < cap_cnt_q);
                tx_valid = tx_valid_q;
                tx_data  = tx_data_q;
            end
            S_FLUSH: rd_en = !rd_pend_q && !bus.fifo_empty;
            default: ;
        endcase
    end

    assign bus.cmd_ready  = cmd_ready;
    assign bus.fifo_rd_en = rd_en;
    assign bus.tx_valid   = tx_valid;
    assign bus.tx_data    = tx_data;
    assign bus.busy       = (state_q != S_IDLE);
    assign bus.done       = (state_q == S_FIN);
    assign bus.truncated  = trunc_q;
endmodule
